// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcode and FSM encodings shared by alu_seq and alu_seq_iter.
// Optional multiply support is controlled by the ALU_SEQ_MUL_EN macro.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_INC = 4'h1,
    OP_DEC = 4'h2,
    OP_ADD = 4'h3,
    OP_ADC = 4'h4,
    OP_SHL = 4'h5,
    OP_SHR = 4'h6,
    OP_SUB = 4'h7,
    OP_SBB = 4'h8,
    OP_MUL = 4'h9,
    OP_AND = 4'hA,
    OP_OR  = 4'hB,
    OP_XOR = 4'hC,
    OP_NOT = 4'hD,
    OP_CMP = 4'hE,
    OP_ROR = 4'hF
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
`ifdef ALU_SEQ_MUL_EN
    ST_MUL,
`endif
    ST_FIN
  } alu_state_e;

  function automatic logic is_shift(alu_op_e op);
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROR);
  endfunction

  // Ops that may occupy the iteration datapath (a zero shift still runs single-cycle).
  function automatic logic is_multicycle(alu_op_e op);
`ifdef ALU_SEQ_MUL_EN
    return is_shift(op) || (op == OP_MUL);
`else
    return is_shift(op);
`endif
  endfunction

endpackage

// File: rtl/alu_seq_iter.sv
// alu_seq_iter: shared one-bit-per-cycle shift / shift-add multiply datapath.
// Loaded on start, steps once per cycle while busy, and exposes the value the
// next step will produce so the owner can capture the final result on the
// same edge as the last step. Multiply hardware exists only with ALU_SEQ_MUL_EN.
module alu_seq_iter
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  alu_op_e          mode,
  input  logic [WIDTH-1:0] operand,
`ifdef ALU_SEQ_MUL_EN
  input  logic [WIDTH-1:0] multiplicand,
  output logic [WIDTH-1:0] next_hi,
`endif
  input  logic [SHW:0]     count,
  output logic             busy,
  output logic             last,
  output logic [WIDTH-1:0] next_lo,
  output logic             next_lcarry
);

  alu_op_e          mode_q;
  logic [WIDTH-1:0] sr;
  logic [SHW:0]     cnt;
`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH:0]   sum;
`endif

  assign last = busy && (cnt == (SHW+1)'(1));

  // Value produced by one step of the selected operation.
  always_comb begin
    next_lo     = sr;
    next_lcarry = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    next_hi = acc;
    sum     = {1'b0, acc} + (sr[0] ? {1'b0, mcand} : '0);
`endif
    case (mode_q)
      OP_SHL: begin
        next_lo     = {sr[WIDTH-2:0], 1'b0};
        next_lcarry = sr[WIDTH-1];
      end
      OP_SHR: begin
        next_lo     = {1'b0, sr[WIDTH-1:1]};
        next_lcarry = sr[0];
      end
      OP_ROR: begin
        next_lo     = {sr[0], sr[WIDTH-1:1]};
        next_lcarry = sr[0];
      end
`ifdef ALU_SEQ_MUL_EN
      OP_MUL: begin
        // Product lives in {acc, sr}; multiplier bits retire from sr[0].
        next_hi = sum[WIDTH:1];
        next_lo = {sum[0], sr[WIDTH-1:1]};
      end
`endif
      default: ;
    endcase
  end

  // Load on start, then step and count down until the terminal count.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy   <= 1'b0;
      cnt    <= '0;
      sr     <= '0;
      mode_q <= OP_NOP;
`ifdef ALU_SEQ_MUL_EN
      acc    <= '0;
      mcand  <= '0;
`endif
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= count;
      sr     <= operand;
      mode_q <= mode;
`ifdef ALU_SEQ_MUL_EN
      acc    <= '0;
      mcand  <= multiplicand;
`endif
    end else if (busy) begin
      sr  <= next_lo;
      cnt <= cnt - (SHW+1)'(1);
`ifdef ALU_SEQ_MUL_EN
      acc <= next_hi;
`endif
      if (last) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with registered result/flag file and valid/ready issue.
// Single-cycle ops retire on the accept edge; shifts and multiply run on
// alu_seq_iter and retire through FIN. Define ALU_SEQ_MUL_EN to include MUL;
// without it opcode 9 behaves as NOP and result_hi is tied to zero.
//
// state    | meaning
// IDLE     | ready; single-cycle ops complete here
// SHIFT    | iterating a shift/rotate, one bit per cycle
// MUL      | iterating shift-add multiply (ALU_SEQ_MUL_EN only)
// FIN      | result/flags just written, done high, still busy
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] lhs_in,
  input  logic [WIDTH-1:0] rhs_in,
  input  logic             assert_bus,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_en,
  output logic [WIDTH-1:0] result_hi,
  output logic             done,
  output logic             flag_zero,
  output logic             flag_acarry,
  output logic             flag_lcarry,
  output logic             flag_sign,
  output logic             flag_overflow
);

  localparam logic [SHW:0] MUL_COUNT = (SHW+1)'(WIDTH);

  alu_state_e       state, state_nxt;
  alu_op_e          op_in;
  logic             busy, accept, go_multi;
  logic [SHW-1:0]   shamt;
  logic [SHW:0]     iter_count;
  logic             iter_busy, iter_last, iter_lc;
  logic [WIDTH-1:0] iter_lo;
  logic [WIDTH-1:0] result;

  logic [WIDTH-1:0] b_opnd;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic             sum_ov;
  logic [WIDTH-1:0] sc_val;
  logic             wr_res, wr_zs, wr_arith, wr_lc;

  assign op_in      = alu_op_e'(operation);
  assign shamt      = rhs_in[SHW-1:0];
  assign accept     = op_valid && op_ready;
  assign go_multi   = accept && is_multicycle(op_in) &&
                      !(is_shift(op_in) && (shamt == '0));
  assign iter_count = (op_in == OP_MUL) ? MUL_COUNT : {1'b0, shamt};

`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0] iter_hi;
`endif

  alu_seq_iter #(.WIDTH(WIDTH), .SHW(SHW)) u_iter (
    .clk          (clk),
    .reset        (reset),
    .start        (go_multi),
    .mode         (op_in),
    .operand      (lhs_in),
`ifdef ALU_SEQ_MUL_EN
    .multiplicand (rhs_in),
    .next_hi      (iter_hi),
`endif
    .count        (iter_count),
    .busy         (iter_busy),
    .last         (iter_last),
    .next_lo      (iter_lo),
    .next_lcarry  (iter_lc)
  );

  // Adder operand and carry-in select; subtracts add the inverted rhs.
  always_comb begin
    b_opnd = rhs_in;
    cin    = 1'b0;
    case (op_in)
      OP_INC: b_opnd = WIDTH'(1);
      OP_DEC: begin b_opnd = ~WIDTH'(1); cin = 1'b1; end
      OP_ADC: cin = flag_acarry;
      OP_SUB, OP_CMP: begin b_opnd = ~rhs_in; cin = 1'b1; end
      OP_SBB: begin b_opnd = ~rhs_in; cin = flag_acarry; end
      default: ;
    endcase
  end

  assign sum    = {1'b0, lhs_in} + {1'b0, b_opnd} + {{WIDTH{1'b0}}, cin};
  assign sum_ov = (lhs_in[WIDTH-1] == b_opnd[WIDTH-1]) &&
                  (sum[WIDTH-1] != lhs_in[WIDTH-1]);

  // Single-cycle result value and which parts of the register file it writes.
  always_comb begin
    sc_val   = result;
    wr_res   = 1'b0;
    wr_zs    = 1'b0;
    wr_arith = 1'b0;
    wr_lc    = 1'b0;
    case (op_in)
      OP_INC, OP_DEC, OP_ADD, OP_ADC, OP_SUB, OP_SBB: begin
        sc_val = sum[WIDTH-1:0]; wr_res = 1'b1; wr_zs = 1'b1; wr_arith = 1'b1;
      end
      OP_CMP: begin
        sc_val = sum[WIDTH-1:0]; wr_zs = 1'b1; wr_arith = 1'b1;
      end
      OP_AND: begin sc_val = lhs_in & rhs_in; wr_res = 1'b1; wr_zs = 1'b1; wr_lc = 1'b1; end
      OP_OR:  begin sc_val = lhs_in | rhs_in; wr_res = 1'b1; wr_zs = 1'b1; wr_lc = 1'b1; end
      OP_XOR: begin sc_val = lhs_in ^ rhs_in; wr_res = 1'b1; wr_zs = 1'b1; wr_lc = 1'b1; end
      OP_NOT: begin sc_val = ~lhs_in;         wr_res = 1'b1; wr_zs = 1'b1; wr_lc = 1'b1; end
      // Reached only for a zero shift amount.
      OP_SHL, OP_SHR, OP_ROR: begin
        sc_val = lhs_in; wr_res = 1'b1; wr_zs = 1'b1; wr_lc = 1'b1;
      end
      default: ;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (go_multi) begin
`ifdef ALU_SEQ_MUL_EN
          state_nxt = (op_in == OP_MUL) ? ST_MUL : ST_SHIFT;
`else
          state_nxt = ST_SHIFT;
`endif
        end
      end
      ST_SHIFT: if (iter_last) state_nxt = ST_FIN;
`ifdef ALU_SEQ_MUL_EN
      ST_MUL:   if (iter_last) state_nxt = ST_FIN;
`endif
      ST_FIN:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy     = (state != ST_IDLE);
    op_ready = !busy;
  end

  // Result/flag file: written on a single-cycle accept or on the last iteration.
  always_ff @(posedge clk) begin
    if (reset) begin
      result        <= '0;
      done          <= 1'b0;
      flag_zero     <= 1'b0;
      flag_acarry   <= 1'b0;
      flag_lcarry   <= 1'b0;
      flag_sign     <= 1'b0;
      flag_overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept && !go_multi) begin
        done <= 1'b1;
        if (wr_res) result <= sc_val;
        if (wr_zs) begin
          flag_zero <= (sc_val == '0);
          flag_sign <= sc_val[WIDTH-1];
        end
        if (wr_arith) begin
          flag_acarry   <= sum[WIDTH];
          flag_overflow <= sum_ov;
        end
        if (wr_lc) flag_lcarry <= 1'b0;
      end else if (iter_last) begin
        done      <= 1'b1;
        result    <= iter_lo;
        flag_sign <= iter_lo[WIDTH-1];
`ifdef ALU_SEQ_MUL_EN
        if (state == ST_MUL) begin
          flag_zero     <= ({iter_hi, iter_lo} == '0);
          flag_acarry   <= (iter_hi != '0);
          flag_overflow <= 1'b0;
        end else begin
          flag_zero   <= (iter_lo == '0);
          flag_lcarry <= iter_lc;
        end
`else
        flag_zero   <= (iter_lo == '0);
        flag_lcarry <= iter_lc;
`endif
      end
    end
  end

`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0] hi_q;

  // Upper product half; any other result-writing op clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
    end else if (accept && !go_multi) begin
      if (wr_res) hi_q <= '0;
    end else if (iter_last) begin
      hi_q <= (state == ST_MUL) ? iter_hi : '0;
    end
  end

  assign result_hi = hi_q;
`else
  assign result_hi = '0;
`endif

  assign bus_out = assert_bus ? result : '0;
  assign bus_en  = assert_bus;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq (WIDTH=8); directed cases then random ops.
module tb_alu_seq;

  localparam int OP_NOP = 0, OP_INC = 1, OP_DEC = 2, OP_ADD = 3, OP_ADC = 4;
  localparam int OP_SHL = 5, OP_SHR = 6, OP_SUB = 7, OP_SBB = 8, OP_MUL = 9;
  localparam int OP_AND = 10, OP_OR = 11, OP_XOR = 12, OP_NOT = 13, OP_CMP = 14, OP_ROR = 15;

  logic       clk = 1'b0;
  logic       reset, op_valid, assert_bus;
  logic [3:0] operation;
  logic [7:0] lhs_in, rhs_in;
  logic       op_ready, bus_en, done;
  logic [7:0] bus_out, result_hi;
  logic       flag_zero, flag_acarry, flag_lcarry, flag_sign, flag_overflow;

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .operation(operation), .lhs_in(lhs_in), .rhs_in(rhs_in),
    .assert_bus(assert_bus), .bus_out(bus_out), .bus_en(bus_en),
    .result_hi(result_hi), .done(done),
    .flag_zero(flag_zero), .flag_acarry(flag_acarry), .flag_lcarry(flag_lcarry),
    .flag_sign(flag_sign), .flag_overflow(flag_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int res; int hi; int z; int ac; int lc; int s; int ov;
  } exp_t;

  exp_t q[$];
  int n_vec = 0, n_err = 0, n_acc = 0, n_done = 0;
  int m_res = 0, m_hi = 0, m_z = 0, m_ac = 0, m_lc = 0, m_s = 0, m_ov = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sx(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  task automatic model_reset();
    m_res = 0; m_hi = 0; m_z = 0; m_ac = 0; m_lc = 0; m_s = 0; m_ov = 0;
  endtask

  // Reference behaviour, computed with plain integer arithmetic.
  task automatic model_op(input int op, input int a, input int b);
    int full, sres, r, n, borrow;
    bit arith, is_sub, wr;
    arith = 0; is_sub = 0; wr = 1; r = 0; n = b % 8; full = 0; sres = 0;
    case (op)
      OP_INC: begin arith = 1; b = 1; borrow = 0; end
      OP_DEC: begin arith = 1; is_sub = 1; b = 1; borrow = 0; end
      OP_ADD: begin arith = 1; borrow = 0; end
      OP_ADC: begin arith = 1; borrow = m_ac; end
      OP_SUB: begin arith = 1; is_sub = 1; borrow = 0; end
      OP_SBB: begin arith = 1; is_sub = 1; borrow = 1 - m_ac; end
      OP_CMP: begin arith = 1; is_sub = 1; borrow = 0; wr = 0; end
      default: borrow = 0;
    endcase
    if (arith) begin
      if (is_sub) begin
        full = a - b - borrow;
        sres = sx(a) - sx(b) - borrow;
        m_ac = (full >= 0) ? 1 : 0;
        r = (full + 512) % 256;
      end else begin
        // for additions 'borrow' holds the carry in
        full = a + b + borrow;
        sres = sx(a) + sx(b) + borrow;
        m_ac = full / 256;
        r = full % 256;
      end
      m_ov = (sres > 127 || sres < -128) ? 1 : 0;
      m_z = (r == 0); m_s = r / 128;
      if (wr) begin m_res = r; m_hi = 0; end
    end else begin
      case (op)
        OP_AND, OP_OR, OP_XOR, OP_NOT: begin
          if (op == OP_AND) r = a & b;
          else if (op == OP_OR) r = a | b;
          else if (op == OP_XOR) r = a ^ b;
          else r = 255 - a;
          m_lc = 0; m_res = r; m_hi = 0; m_z = (r == 0); m_s = r / 128;
        end
        OP_SHL, OP_SHR, OP_ROR: begin
          if (n == 0) begin
            r = a; m_lc = 0;
          end else if (op == OP_SHL) begin
            r = (a << n) % 256; m_lc = (a >> (8 - n)) & 1;
          end else if (op == OP_SHR) begin
            r = a >> n; m_lc = (a >> (n - 1)) & 1;
          end else begin
            r = ((a >> n) | (a << (8 - n))) % 256; m_lc = r / 128;
          end
          m_res = r; m_hi = 0; m_z = (r == 0); m_s = r / 128;
        end
`ifdef ALU_SEQ_MUL_EN
        OP_MUL: begin
          full = a * b;
          m_res = full % 256; m_hi = full / 256;
          m_ac = (m_hi != 0); m_ov = 0; m_z = (full == 0); m_s = m_res / 128;
        end
`endif
        default: ;
      endcase
    end
  endtask

  // Present an op (driven just after a rising edge) and hold it until accepted.
  task automatic issue(input int op, input int a, input int b, input bit ab, input bit track);
    exp_t e;
    int t;
    operation = op[3:0]; lhs_in = a[7:0]; rhs_in = b[7:0]; assert_bus = ab; op_valid = 1'b1;
    t = 0;
    while (!op_ready) begin
      @(posedge clk); #1;
      t++;
      if (t > 40) begin
        $display("FAIL issue_timeout: op_ready stuck low, got 0 expected 1");
        $fatal(1, "op_ready timeout");
      end
    end
    @(posedge clk);
    if (track) begin
      model_op(op, a, b);
      e = '{m_res, m_hi, m_z, m_ac, m_lc, m_s, m_ov};
      q.push_back(e);
      n_acc++;
    end
    #1;
  endtask

  task automatic idle(input int n);
    op_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Cycles from accept to done, and cycles op_ready spends low meanwhile.
  task automatic measure(input string name, input int exp_lat);
    int low, lat;
    op_valid = 1'b0; low = 0; lat = 0;
    for (int i = 1; i <= 40; i++) begin
      if (!op_ready) low++;
      @(negedge clk);
      if (done) begin lat = i; break; end
      @(posedge clk); #1;
    end
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_ready_low"}, low, (exp_lat == 1) ? 0 : exp_lat);
    @(posedge clk); #1;
    check({name, "_ready_after"}, op_ready, 1);
  endtask

  task automatic check_regs(input string name, input int res, input int hi,
                            input int z, input int ac, input int lc);
    check({name, "_bus"}, bus_out, res);
    check({name, "_hi"}, result_hi, hi);
    check({name, "_zero"}, flag_zero, z);
    check({name, "_acarry"}, flag_acarry, ac);
    check({name, "_lcarry"}, flag_lcarry, lc);
  endtask

  // Scoreboard monitor: every done pops one expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && done) begin
        n_done++;
        if (q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = q.pop_front();
          check("bus_out", bus_out, assert_bus ? e.res : 0);
          check("bus_en", bus_en, assert_bus);
          check("result_hi", result_hi, e.hi);
          check("flag_zero", flag_zero, e.z);
          check("flag_acarry", flag_acarry, e.ac);
          check("flag_lcarry", flag_lcarry, e.lc);
          check("flag_sign", flag_sign, e.s);
          check("flag_overflow", flag_overflow, e.ov);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int op, a, b, t;
    reset = 1'b1; op_valid = 1'b0; assert_bus = 1'b1;
    operation = '0; lhs_in = '0; rhs_in = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_ready", op_ready, 1);
    check("rst_done", done, 0);
    check_regs("rst", 0, 0, 0, 0, 0);
    check("rst_sign", flag_sign, 0);
    check("rst_ovf", flag_overflow, 0);

    issue(OP_AND, 8'h55, 8'hAA, 1, 1);
    measure("and", 1);
    check_regs("and", 8'h00, 0, 1, 0, 0);

    issue(OP_ADD, 200, 64, 1, 1);
    issue(OP_ADC, 0, 0, 1, 1);
    issue(OP_ADC, 0, 0, 1, 1);
    idle(2);
    check_regs("adc", 8'h00, 0, 1, 0, 0);

    issue(OP_SUB, 8'h01, 8'h81, 1, 1);
    issue(OP_CMP, 8'h05, 8'h05, 1, 1);
    idle(2);
    check_regs("cmp", 8'h80, 0, 1, 1, 0);

    issue(OP_SHL, 8'h81, 3, 1, 1);
    measure("shl3", 4);
    check_regs("shl3", 8'h08, 0, 0, 1, 0);
    issue(OP_SHR, 8'h81, 1, 1, 1);
    measure("shr1", 2);
    check_regs("shr1", 8'h40, 0, 0, 1, 1);
    issue(OP_ROR, 8'h01, 1, 1, 1);
    measure("ror1", 2);
    issue(OP_SHL, 8'h5A, 8, 1, 1);
    measure("shl0", 1);

`ifdef ALU_SEQ_MUL_EN
    issue(OP_MUL, 13, 11, 1, 1);
    measure("mul13", 9);
    check_regs("mul13", 8'h8F, 8'h00, 0, 0, 0);
    issue(OP_MUL, 255, 255, 1, 1);
    measure("mulff", 9);
    check_regs("mulff", 8'h01, 8'hFE, 0, 1, 0);
    issue(OP_MUL, 13, 11, 1, 0);
`else
    issue(OP_MUL, 13, 11, 1, 1);
    measure("mulnop", 1);
    issue(OP_SHL, 8'h81, 7, 1, 0);
`endif
    // abort in the fourth busy cycle
    idle(3);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    check("abort_ready", op_ready, 1);
    check("abort_done", done, 0);
    check_regs("abort", 0, 0, 0, 0, 0);
    check("abort_sign", flag_sign, 0);
    idle(12);

    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 15);
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      if ((op == OP_SHL || op == OP_SHR || op == OP_ROR) && $urandom_range(0, 1) == 1)
        b = $urandom_range(0, 7);
      issue(op, a, b, ($urandom_range(0, 7) != 0), 1);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    op_valid = 1'b0;
    t = 0;
    while (q.size() != 0 && t < 50) begin @(posedge clk); #1; t++; end
    idle(2);
    check("pending_expectations", q.size(), 0);
    check("done_count", n_done, n_acc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
